// File: rtl/icap_wb_loader.sv
// Wishbone master that streams bytes into the ICAP slave or reads status bytes back.
// Each byte is one single-beat Wishbone cycle. A timeout or an abort ends the job with a sticky error.
module icap_wb_loader #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNTW    = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            rd_mode,
  input  logic [CNTW-1:0] length,
  input  logic            abort,
  input  logic [7:0]      in_dat,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [7:0]      out_dat,
  output logic            out_valid,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [31:0]     dat_o,
  input  logic [31:0]     dat_i,
  input  logic            ack_i,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [CNTW-1:0] progress
);
  localparam int unsigned WAITW = 16;
  localparam int unsigned DATW  = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WB_WR, S_WB_RD, S_RD_GAP, S_DONE, S_ERR
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNTW-1:0]  r_remaining, w_remaining_nxt;
  logic [CNTW-1:0]  r_progress, w_progress_nxt;
  logic [WAITW-1:0] r_wait, w_wait_nxt;
  logic [DATW-1:0]  r_dat_o, w_dat_o_nxt;
  logic [7:0]       r_out_dat, w_out_dat_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_error, w_error_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_cyc, w_cyc_nxt;
  logic             r_we, w_we_nxt;
  logic             r_in_ready, w_in_ready_nxt;
  logic             w_in_wb, w_ack, w_tmo, w_last;
  logic             w_unused_dat;

  // The upper bits of the read data are never used.
  assign w_unused_dat = ^dat_i[DATW-1:8];

  assign w_in_wb = (r_state == S_WB_WR) || (r_state == S_WB_RD);
  assign w_ack   = w_in_wb && ack_i;
  assign w_tmo   = w_in_wb && !ack_i && (r_wait == WAITW'(TIMEOUT));
  assign w_last  = (r_remaining == CNTW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_progress  <= '0;
      r_wait      <= '0;
      r_dat_o     <= '0;
      r_out_dat   <= '0;
      r_out_valid <= 1'b0;
      r_error     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_progress  <= w_progress_nxt;
      r_wait      <= w_wait_nxt;
      r_dat_o     <= w_dat_o_nxt;
      r_out_dat   <= w_out_dat_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_error     <= w_error_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_progress_nxt  = r_progress;
    w_dat_o_nxt     = r_dat_o;
    w_out_dat_nxt   = r_out_dat;
    w_out_valid_nxt = 1'b0;
    w_error_nxt     = r_error;
    w_wait_nxt      = (w_in_wb && !ack_i) ? r_wait + 1'b1 : '0;

    // An acknowledged byte always counts, even when abort or timeout hits in the same cycle.
    if (w_ack) begin
      w_progress_nxt  = (&r_progress) ? r_progress : r_progress + 1'b1;
      w_remaining_nxt = r_remaining - 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_remaining_nxt = length;
          w_progress_nxt  = '0;
          w_error_nxt     = 1'b0;
          if (length == '0)  w_state_nxt = S_DONE;
          else if (rd_mode)  w_state_nxt = S_WB_RD;
          else               w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (in_valid && r_in_ready) begin
          w_dat_o_nxt = DATW'(in_dat);
          w_state_nxt = S_WB_WR;
        end
      end
      S_WB_WR: begin
        if (ack_i)      w_state_nxt = w_last ? S_DONE : S_FETCH;
        else if (w_tmo) w_state_nxt = S_ERR;
      end
      S_WB_RD: begin
        if (ack_i) begin
          w_out_dat_nxt   = dat_i[7:0];
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = w_last ? S_DONE : S_RD_GAP;
        end else if (w_tmo) begin
          w_state_nxt = S_ERR;
        end
      end
      S_RD_GAP: w_state_nxt = S_WB_RD;
      default:  w_state_nxt = S_IDLE;
    endcase

    if (abort && (r_state != S_IDLE) && (r_state != S_ERR)) w_state_nxt = S_ERR;
    if (w_state_nxt == S_ERR) w_error_nxt = 1'b1;

    // Outputs are registered and decoded from the state being entered.
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_busy_nxt     = (w_state_nxt == S_FETCH) || (w_state_nxt == S_WB_WR) ||
                     (w_state_nxt == S_WB_RD) || (w_state_nxt == S_RD_GAP);
    w_cyc_nxt      = (w_state_nxt == S_WB_WR) || (w_state_nxt == S_WB_RD);
    w_we_nxt       = (w_state_nxt == S_WB_WR);
    w_in_ready_nxt = (w_state_nxt == S_FETCH);
  end

  assign in_ready  = r_in_ready;
  assign out_dat   = r_out_dat;
  assign out_valid = r_out_valid;
  assign cyc_o     = r_cyc;
  assign stb_o     = r_cyc;
  assign we_o      = r_we;
  assign dat_o     = r_dat_o;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign progress  = r_progress;

endmodule

// File: tb/tb_icap_wb_loader.sv
// Bench for icap_wb_loader: an ICAP-like slave model plus directed and random jobs.
// Expected values come from a per-job reference model built on byte counts and latency arithmetic.
module tb_icap_wb_loader;
  localparam int unsigned TMO    = 8;
  localparam int unsigned CW     = 32;
  localparam int unsigned BUDGET = 300;

  logic          clk = 1'b0;
  logic          reset_n, start, rd_mode, abort, in_valid, in_ready, out_valid;
  logic          cyc_o, stb_o, we_o, ack_i, busy, done, error;
  logic [CW-1:0] length, progress;
  logic [7:0]    in_dat, out_dat;
  logic [31:0]   dat_o, dat_i;

  always #5 clk = ~clk;

  icap_wb_loader #(.TIMEOUT(TMO), .CNTW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rd_mode(rd_mode), .length(length),
    .abort(abort), .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .out_dat(out_dat), .out_valid(out_valid), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .busy(busy), .done(done),
    .error(error), .progress(progress)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Slave model: acks in strobe cycle s_lat (0 means never), logs traffic.
  int unsigned s_lat = 3;
  int unsigned s_cnt = 0;
  logic [3:0]  rd_idx = '0;
  logic [7:0]  rd_mem [0:15];
  logic [31:0] wlog   [0:255];
  logic [7:0]  olog   [0:255];
  logic [7:0]  wcnt = '0;
  logic [7:0]  ocnt = '0;
  int unsigned acc_cnt = 0, done_cnt = 0, b2b_err = 0, ovl_err = 0;
  logic        prev_ack = 1'b0;

  assign ack_i = cyc_o && stb_o && (s_lat != 0) && (s_cnt == s_lat - 1);
  assign dat_i = {24'hFF_FFFF, rd_mem[rd_idx]};

  always @(posedge clk) begin
    s_cnt    <= (cyc_o && stb_o && !ack_i) ? s_cnt + 1 : 0;
    prev_ack <= ack_i;
    if (prev_ack && stb_o) b2b_err <= b2b_err + 1;
    if (in_ready && cyc_o) ovl_err <= ovl_err + 1;
    if (ack_i && we_o) begin
      wlog[wcnt] <= dat_o;
      wcnt       <= wcnt + 8'd1;
    end
    if (ack_i && !we_o) rd_idx <= rd_idx + 4'd1;
    if (out_valid) begin
      olog[ocnt] <= out_dat;
      ocnt       <= ocnt + 8'd1;
    end
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Per-job stimulus and observations.
  logic [7:0]  jb   [0:15];
  int unsigned jgap [0:15];
  bit          j_fin, j_on_seen, j_off_seen, j_err0, j_ab_cyc, j_ab_err, j_ab_busy;
  int unsigned j_end, j_on, j_off, j_we_bad;
  int unsigned b_acc, b_done;
  logic [7:0]  b_w, b_o;
  logic [3:0]  b_rd;

  task automatic run_job(input bit rd, input int unsigned len, input int unsigned lat,
                         input int abort_at);
    int unsigned gap;
    int          last;
    int unsigned idx;
    gap  = 0;
    last = -1;
    s_lat = lat;
    @(negedge clk);
    b_acc = acc_cnt; b_done = done_cnt; b_w = wcnt; b_o = ocnt; b_rd = rd_idx;
    rd_mode = rd; length = CW'(len); start = 1'b1; in_valid = 1'b0;
    j_fin = 0; j_on_seen = 0; j_off_seen = 0; j_err0 = 0;
    j_ab_cyc = 0; j_ab_err = 0; j_ab_busy = 0;
    j_end = 0; j_on = 0; j_off = 0; j_we_bad = 0;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned k = 0; k < BUDGET && !j_fin; k++) begin
      if (k == 0) j_err0 = error;
      if (cyc_o && !j_on_seen) begin j_on_seen = 1; j_on = k; end
      if (j_on_seen && !cyc_o && !j_off_seen) begin j_off_seen = 1; j_off = k; end
      if (rd && we_o) j_we_bad++;
      if (abort_at >= 0 && int'(k) == abort_at + 1) begin
        j_ab_cyc = cyc_o | stb_o; j_ab_err = error; j_ab_busy = busy;
      end
      if (done || (error && !busy)) begin j_fin = 1; j_end = k; end
      abort = (abort_at >= 0) && (int'(k) == abort_at);
      idx = acc_cnt - b_acc;
      if (!rd && idx < len) begin
        if (int'(idx) != last) begin gap = jgap[4'(idx)]; last = int'(idx); end
        in_dat = jb[4'(idx)];
        if (in_ready && gap > 0) begin gap--; in_valid = 1'b0; end
        else in_valid = (gap == 0);
      end else begin
        in_valid = 1'b0;
      end
      if (!j_fin) @(negedge clk);
    end
    abort = 1'b0; in_valid = 1'b0;
    check("job_ended", 32'(j_fin), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Reference: writes take (lat+1) per byte plus stall cycles; reads drop the final gap.
  task automatic check_job(input bit rd, input int unsigned len, input int unsigned lat,
                           input int unsigned gsum);
    logic [7:0] n;
    check("cycles", j_end, rd ? len * (lat + 1) - 1 : len * (lat + 1) + gsum);
    check("done_cnt", done_cnt - b_done, 32'd1);
    check("progress", progress, len);
    check("error", 32'(error), 32'd0);
    check("busy", 32'(busy), 32'd0);
    check("we_in_read", j_we_bad, 32'd0);
    if (rd) begin
      n = ocnt - b_o;
      check("n_out", 32'(n), len);
      for (int unsigned i = 0; i < len; i++)
        check("rd_byte", 32'(olog[b_o + 8'(i)]), 32'(rd_mem[b_rd + 4'(i)]));
    end else begin
      n = wcnt - b_w;
      check("n_wr", 32'(n), len);
      for (int unsigned i = 0; i < len; i++)
        check("wr_data", wlog[b_w + 8'(i)], {24'd0, jb[4'(i)]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] n;
    reset_n = 1'b0; start = 1'b0; rd_mode = 1'b0; length = '0; abort = 1'b0;
    in_valid = 1'b0; in_dat = '0;
    for (int i = 0; i < 16; i++) begin
      rd_mem[i] = 8'(i * 17); jb[i] = '0; jgap[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_ctl", 32'({cyc_o, stb_o, we_o, in_ready, out_valid, done, busy, error}), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_prog", progress, 32'd0);
    check("rst_out", 32'(out_dat), 32'd0);
    reset_n = 1'b1;

    // Three-byte write, in_valid held high: done 12 cycles after start.
    jb[0] = 8'hAA; jb[1] = 8'h99; jb[2] = 8'h55;
    run_job(1'b0, 3, 3, -1);
    check_job(1'b0, 3, 3, 0);

    // Five-cycle stall before the second byte.
    jb[0] = 8'h5A; jb[1] = 8'hA5; jgap[1] = 5;
    run_job(1'b0, 2, 3, -1);
    check_job(1'b0, 2, 3, 5);
    jgap[1] = 0;

    // Two-byte read with junk in the upper data bits.
    rd_mem[rd_idx] = 8'h12; rd_mem[rd_idx + 4'd1] = 8'h34;
    run_job(1'b1, 2, 3, -1);
    check_job(1'b1, 2, 3, 0);

    // Slave never acks: strobe drops TIMEOUT+1 cycles after it rose.
    jb[0] = 8'h3C;
    run_job(1'b0, 1, 0, -1);
    check("tmo_strobe", 32'(j_on_seen), 32'd1);
    check("tmo_drop", j_off - j_on, TMO + 1);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_done", done_cnt - b_done, 32'd0);
    check("tmo_prog", progress, 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);

    // Next start clears the sticky error.
    run_job(1'b0, 1, 3, -1);
    check("err_cleared", 32'(j_err0), 32'd0);
    check_job(1'b0, 1, 3, 0);

    // Ack in the very cycle the timeout would fire still counts.
    jb[0] = 8'hE7;
    run_job(1'b0, 1, TMO + 1, -1);
    check_job(1'b0, 1, TMO + 1, 0);

    // Abort in the second cycle of the second write.
    for (int i = 0; i < 4; i++) jb[i] = 8'($urandom);
    run_job(1'b0, 4, 3, 6);
    check("ab_cyc", 32'(j_ab_cyc), 32'd0);
    check("ab_err", 32'(j_ab_err), 32'd1);
    check("ab_busy", 32'(j_ab_busy), 32'd0);
    check("ab_prog", progress, 32'd1);
    check("ab_done", done_cnt - b_done, 32'd0);
    n = wcnt - b_w;
    check("ab_nwr", 32'(n), 32'd1);

    // Abort coincident with the first ack: byte counts, job errors.
    run_job(1'b0, 4, 3, 3);
    check("abk_prog", progress, 32'd1);
    check("abk_err", 32'(error), 32'd1);
    n = wcnt - b_w;
    check("abk_nwr", 32'(n), 32'd1);

    // Zero-length job: done on the next cycle, no bus activity.
    run_job(1'b0, 0, 3, -1);
    check("len0_bus", 32'(j_on_seen), 32'd0);
    check_job(1'b0, 0, 3, 0);

    // Abort while idle does nothing.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    check("idle_abort_err", 32'(error), 32'd0);
    check("idle_abort_busy", 32'({busy, cyc_o}), 32'd0);

    // Random jobs.
    for (int j = 0; j < 10; j++) begin
      bit          rd;
      int unsigned len, lat, gsum;
      rd   = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 5);
      lat  = $urandom_range(1, 5);
      gsum = 0;
      for (int unsigned i = 0; i < len; i++) begin
        jb[4'(i)]   = 8'($urandom);
        jgap[4'(i)] = rd ? 0 : $urandom_range(0, 3);
        gsum       += jgap[4'(i)];
        rd_mem[rd_idx + 4'(i)] = 8'($urandom);
      end
      run_job(rd, len, lat, -1);
      check_job(rd, len, lat, gsum);
      for (int i = 0; i < 16; i++) jgap[i] = 0;
    end

    // Asynchronous reset in the middle of a write strobe.
    s_lat = 3;
    @(negedge clk);
    rd_mode = 1'b0; length = CW'(3); start = 1'b1; in_dat = 8'hC3; in_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_cyc", 32'(cyc_o), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ctl", 32'({cyc_o, stb_o, we_o, in_ready, out_valid, done, busy, error}), 32'd0);
    check("arst_dat", dat_o, 32'd0);
    check("arst_out", 32'(out_dat), 32'd0);
    in_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    rd_mem[rd_idx] = 8'h6B;
    run_job(1'b1, 1, 2, -1);
    check_job(1'b1, 1, 2, 0);

    check("no_b2b_strobe", b2b_err, 32'd0);
    check("no_cyc_in_fetch", ovl_err, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/icap_wb_loader.md
Name: icap_wb_loader

Overview:
- Wishbone master that streams configuration bytes into the ICAP Wishbone slave, or reads status bytes back from it.
- Write mode: takes bytes from a valid/ready byte stream, for example a bitstream FIFO fed from the SD or Ethernet path, and issues one single-beat Wishbone write per byte.
- Read mode: issues single-beat reads and presents each returned byte on an output strobe.
- Sits between the firmware/control path and the ICAP slave on the same clock.

Parameters:
- TIMEOUT, 255, cycles a Wishbone cycle may wait for ack_i before it is aborted with an error; range 1..65535.
- CNTW, 32, width of the length and progress counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a job; sampled only in IDLE.
- rd_mode  in  1  sampled with start; 0 = write job, 1 = read job.
- length  in  CNTW  number of bytes in the job; sampled with start.
- abort  in  1  cancels the current job.
- in_dat  in  8  byte to write.
- in_valid  in  1  in_dat is valid.
- in_ready  out  1  loader accepts in_dat this cycle.
- out_dat  out  8  last byte read back.
- out_valid  out  1  one-cycle strobe; out_dat holds a new byte.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- we_o  out  1  Wishbone write enable.
- dat_o  out  32  Wishbone write data; bits [31:8] are always 0.
- dat_i  in  32  Wishbone read data; only [7:0] is used.
- ack_i  in  1  Wishbone acknowledge.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when a job completes normally.
- error  out  1  sticky error flag; set by timeout or abort, cleared by the next accepted start.
- progress  out  CNTW  bytes completed in the current or last job.

Behaviour:
- Reset (async, reset_n=0): state IDLE. cyc_o, stb_o, we_o, in_ready, out_valid, done, busy and error are all 0. dat_o, out_dat and progress are 0.
- States: IDLE, FETCH, WB_WR, WB_RD, DONE, ERR.
- IDLE:
  - start=1: latch rd_mode and length into remaining, clear progress and error, set busy.
  - length=0: go to DONE.
  - Otherwise rd_mode=0 goes to FETCH; rd_mode=1 goes to WB_RD.
  - start outside IDLE is ignored.
- FETCH:
  - in_ready=1.
  - On in_valid&in_ready: dat_o <= {24'd0, in_dat}; go to WB_WR.
  - in_ready is 0 in every other state.
- WB_WR:
  - cyc_o=stb_o=we_o=1; dat_o is held stable.
  - On ack_i: progress+1, remaining-1. If remaining was 1, go to DONE; else go to FETCH.
  - cyc_o/stb_o deassert the cycle after ack_i is sampled, so the slave never sees a back-to-back strobe.
- WB_RD:
  - cyc_o=stb_o=1, we_o=0.
  - On ack_i: out_dat <= dat_i[7:0]; out_valid=1 for exactly that following cycle; progress+1.
  - Go to DONE when remaining reaches 0; otherwise pass through one idle cycle with stb_o=0, then return to WB_RD.
  - There is no backpressure on out_valid.
- Timing against the ICAP slave:
  - Ack arrives in the 3rd cycle of the strobe.
  - Writes take 4 cycles/byte minimum (1 FETCH + 3 WB).
  - Reads take 4 cycles/byte (3 WB + 1 gap).
- Timeout:
  - A wait counter clears on entry to WB_WR or WB_RD and increments each cycle without ack_i.
  - When the counter equals TIMEOUT: drop cyc_o/stb_o next cycle, set error, go to ERR.
  - ack_i in the same cycle as the timeout wins: the byte counts and there is no error.
- abort:
  - In any non-IDLE state: cyc_o/stb_o are 0 from the next cycle, error=1, go to ERR.
  - abort in IDLE has no effect.
  - abort in the same cycle as ack_i: the byte counts in progress, then go to ERR.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- ERR: busy=0 and done stays 0 for one cycle, return to IDLE; error remains 1.
- ack_i outside WB_WR/WB_RD is ignored.
- progress saturates at all-ones; length never exceeds it in practice.

Test Plan:
- Write job, length=3, bytes 0xAA,0x99,0x55 with in_valid held high, slave model acks in the 3rd strobe cycle -> three writes with dat_o=0x000000AA, 0x00000099, 0x00000055; stb_o low at least 1 cycle between writes; done pulses once, 12 cycles after start; progress=3; error=0.
- Write job, length=2, in_valid low for 5 cycles before the 2nd byte -> cyc_o stays 0 during the gap; in_ready stays high; second write completes; done=1, progress=2.
- Read job, length=2, slave returns 0x12 then 0x34 on dat_i[7:0] with 0xFFFFFF in [31:8] -> out_valid pulses twice with out_dat=0x12 then 0x34; we_o=0 throughout; done=1.
- TIMEOUT=8, slave never acks, write length=1 -> cyc_o drops 9 cycles after strobe start; error=1; done never pulses; progress=0; next start clears error.
- abort asserted in the 2nd cycle of the 2nd write of a length=4 job -> cyc_o/stb_o=0 on the next cycle; error=1; progress=1; busy=0 within 2 cycles.
- length=0 start -> done pulses 1 cycle later; no Wishbone activity. reset_n pulled low mid-write -> all outputs 0 immediately, without waiting for a clock edge.
